// File: rtl/axi_bti_s00_axi_regs.sv
// -----------------------------------------------------------------------------
// axi_bti_s00_axi_regs
//
// AXI4-Lite responder for the AXI_BTI S00_AXI port. It holds NUM_REGS 32-bit
// read/write registers and exposes them to the BTI core as one flat vector.
//
// The write and read channels are served by two independent state machines.
// Every response is OKAY. All handshake outputs are registered, so no ready
// depends combinationally on the matching valid.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock (rising edge), sync active-low reset
//   s00_axi_aw*  : write address channel (awprot ignored)
//   s00_axi_w*   : write data channel with byte strobes
//   s00_axi_b*   : write response channel (bresp always OKAY)
//   s00_axi_ar*  : read address channel (arprot ignored)
//   s00_axi_r*   : read data channel (rresp always OKAY)
//   slv_regs_o   : register contents, reg0 in [31:0], reg1 in [63:32], ...
//
// Decoding: the register index is addr[ADDR_LSB +: log2(NUM_REGS)]. Byte-offset
// bits and any higher address bits are ignored, so addresses alias (0x10 is
// reg0 in the default configuration). NUM_REGS must be a power of two >= 2.
// -----------------------------------------------------------------------------
module axi_bti_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                 s00_axi_aclk,
  input  logic                                 s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [2:0]                           s00_axi_awprot,
  input  logic                                 s00_axi_awvalid,
  output logic                                 s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0]    s00_axi_wstrb,
  input  logic                                 s00_axi_wvalid,
  output logic                                 s00_axi_wready,
  output logic [1:0]                           s00_axi_bresp,
  output logic                                 s00_axi_bvalid,
  input  logic                                 s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [2:0]                           s00_axi_arprot,
  input  logic                                 s00_axi_arvalid,
  output logic                                 s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
  output logic [1:0]                           s00_axi_rresp,
  output logic                                 s00_axi_rvalid,
  input  logic                                 s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] slv_regs_o
);

  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int NB       = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_W = 2'd2,
    W_RESP   = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  // Merge new data into an old word, one byte per strobe bit.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_word,
                                               input logic [DW-1:0] new_word,
                                               input logic [NB-1:0] strb);
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Register file and channel state
  logic [DW-1:0]    slv_reg_r [NUM_REGS];
  w_state_t         w_state_r;
  r_state_t         r_state_r;
  logic             awready_r;
  logic             wready_r;
  logic             bvalid_r;
  logic             arready_r;
  logic             rvalid_r;
  logic [DW-1:0]    rdata_r;
  logic [IDX_W-1:0] aw_idx_r;     // address held while waiting for W
  logic [DW-1:0]    w_data_r;     // data held while waiting for AW
  logic [NB-1:0]    w_strb_r;

  logic             aw_hs_s;
  logic             w_hs_s;
  logic             ar_hs_s;
  logic [IDX_W-1:0] aw_idx_s;
  logic [IDX_W-1:0] ar_idx_s;
  logic             commit_s;
  logic [IDX_W-1:0] commit_idx_s;
  logic [DW-1:0]    commit_data_s;
  logic [NB-1:0]    commit_strb_s;
  logic             unused_s;

  assign aw_hs_s  = s00_axi_awvalid & awready_r;
  assign w_hs_s   = s00_axi_wvalid  & wready_r;
  assign ar_hs_s  = s00_axi_arvalid & arready_r;
  assign aw_idx_s = s00_axi_awaddr[ADDR_LSB +: IDX_W];
  assign ar_idx_s = s00_axi_araddr[ADDR_LSB +: IDX_W];

  // Protection bits and unused address bits carry no meaning here.
  assign unused_s = ^{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  // Select the address/data pair that completes a write on this edge.
  always_comb begin
    commit_s      = 1'b0;
    commit_idx_s  = aw_idx_s;
    commit_data_s = s00_axi_wdata;
    commit_strb_s = s00_axi_wstrb;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      W_HAVE_A: begin
        commit_idx_s = aw_idx_r;
        if (w_hs_s) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      W_HAVE_W: begin
        commit_data_s = w_data_r;
        commit_strb_s = w_strb_r;
        if (aw_hs_s) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      W_RESP: begin
        commit_s = 1'b0;
      end
      default: begin
        commit_s = 1'b0;
      end
    endcase
  end

  // Write channel FSM: collects AW and W in either order, then issues B.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      aw_idx_r  <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s && w_hs_s) begin
            w_state_r <= W_RESP;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
          end else if (aw_hs_s) begin
            aw_idx_r  <= aw_idx_s;
            w_state_r <= W_HAVE_A;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
          end else if (w_hs_s) begin
            w_data_r  <= s00_axi_wdata;
            w_strb_r  <= s00_axi_wstrb;
            w_state_r <= W_HAVE_W;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
          end else begin
            // Also the first cycle after reset: readies come up here.
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        W_HAVE_A: begin
          if (w_hs_s) begin
            w_state_r <= W_RESP;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
          end else begin
            wready_r  <= 1'b1;
          end
        end
        W_HAVE_W: begin
          if (aw_hs_s) begin
            w_state_r <= W_RESP;
            awready_r <= 1'b0;
            bvalid_r  <= 1'b1;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end else begin
            bvalid_r  <= 1'b1;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Register file: byte-masked update on the completing write handshake.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        slv_reg_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_s && (commit_idx_s == IDX_W'(i))) begin
          slv_reg_r[i] <= apply_strb(slv_reg_r[i], commit_data_s, commit_strb_s);
        end else begin
          slv_reg_r[i] <= slv_reg_r[i];
        end
      end
    end
  end

  // Read channel FSM: captures the pre-write register value on AR handshake.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            rdata_r   <= slv_reg_r[ar_idx_s];
            r_state_r <= R_RESP;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_RESP: begin
          if (s00_axi_rready) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
          end else begin
            rvalid_r  <= 1'b1;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s00_axi_awready = awready_r;
  assign s00_axi_wready  = wready_r;
  assign s00_axi_bvalid  = bvalid_r;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_r;
  assign s00_axi_rvalid  = rvalid_r;
  assign s00_axi_rdata   = rdata_r;
  assign s00_axi_rresp   = 2'b00;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign slv_regs_o[g*DW +: DW] = slv_reg_r[g];
  end

endmodule

// File: tb/tb_axi_bti_s00_axi_regs.sv
module tb_axi_bti_s00_axi_regs;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [127:0] slv_regs;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  axi_bti_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_REGS(4)
  ) dut (
    .s00_axi_aclk(clk),       .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid),.s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid),.s00_axi_arready(arready),
    .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
    .slv_regs_o(slv_regs)
  );

  // Drives AW and W together and completes B. Inputs change on negedges only.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire, b_done = 1'b0;
    int n = 0;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    resp = 2'b11;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      if (aw_fire) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      n++;
    end
    n = 0;
    while (!b_done && n < 50) begin
      if (bvalid) begin
        resp = bresp;
        b_done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bready = 1'b0;
    ok = aw_done && w_done && b_done;
  endtask

  // Issues one read and returns the data seen with rvalid.
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    bit ar_done = 1'b0, r_done = 1'b0, ar_fire;
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    d = 32'hxxxx_xxxx; resp = 2'b11;
    while (!ar_done && n < 50) begin
      ar_fire = arvalid && arready;
      @(posedge clk);
      @(negedge clk);
      if (ar_fire) begin ar_done = 1'b1; arvalid = 1'b0; end
      n++;
    end
    n = 0;
    while (!r_done && n < 50) begin
      if (rvalid) begin
        d = rdata; resp = rresp; r_done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    ok = ar_done && r_done;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000 || rdata !== 32'h0 || slv_regs !== 128'h0) begin
      fails++;
      $display("FAIL reset_state: rdy/vld=%b rdata=%h regs=%h, need 00000/0/0",
               {awready, wready, arready, bvalid, rvalid}, rdata, slv_regs);
    end
    aresetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      fail_rdy: begin
        fails++;
        $display("FAIL reset_release_ready: %b need 111", {awready, wready, arready});
      end
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp, ok);
      checks++;
      if (!ok || resp !== 2'b00) begin
        fails++;
        $display("FAIL basic_write%0d: ok=%0d bresp=%b need ok=1 bresp=00", i, ok, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp, ok);
      checks++;
      if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
        fails++;
        $display("FAIL basic_read%0d: ok=%0d rdata=%h rresp=%b need %h/00", i, ok, d, resp, 32'(i + 1));
      end
    end
  endtask

  task automatic test_w_before_aw();
    @(negedge clk);
    wdata = 32'hDEAD_0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      fails++;
      $display("FAIL w_first_ready: wready=%b awready=%b bvalid=%b need 0/1/0", wready, awready, bvalid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || wready !== 1'b0) begin
      fails++;
      $display("FAIL w_first_wait: bvalid=%b wready=%b need 0/0", bvalid, wready);
    end
    awaddr = 4'h8; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || slv_regs[95:64] !== 32'hDEAD_0001) begin
      fails++;
      $display("FAIL w_first_commit: bvalid=%b reg2=%h need 1/DEAD0001", bvalid, slv_regs[95:64]);
    end
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      fails++;
      $display("FAIL w_first_single_b: bvalid=%b need 0", bvalid);
    end
  endtask

  task automatic test_strobes();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok, ok2;
    axi_write(4'h4, 32'h1122_3344, 4'hF, resp, ok);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0010, resp, ok2);
    axi_read(4'h4, d, resp, ok);
    checks++;
    if (!ok || !ok2 || d !== 32'h1122_CC44) begin
      fails++;
      $display("FAIL strb_byte1: rdata=%h need 1122CC44", d);
    end
    axi_write(4'h4, 32'hFFFF_FFFF, 4'b0000, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00 || slv_regs[63:32] !== 32'h1122_CC44) begin
      fails++;
      $display("FAIL strb_zero: ok=%0d bresp=%b reg1=%h need 1/00/1122CC44", ok, resp, slv_regs[63:32]);
    end
  endtask

  task automatic test_bready_stall();
    bit hold_bad = 1'b0;
    @(negedge clk);
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h0000_AAAA; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Present the next write immediately; it must wait for the B handshake.
    wdata = 32'h4444_0000;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) hold_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (hold_bad || slv_regs[127:96] !== 32'h0000_AAAA) begin
      fails++;
      $display("FAIL bready_hold: hold_bad=%0d reg3=%h need 0/0000AAAA", hold_bad, slv_regs[127:96]);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || slv_regs[127:96] !== 32'h0000_AAAA) begin
      fails++;
      $display("FAIL bready_release: bvalid=%b awready=%b reg3=%h need 0/1/0000AAAA", bvalid, awready, slv_regs[127:96]);
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || slv_regs[127:96] !== 32'h4444_0000) begin
      fails++;
      $display("FAIL bready_next_write: bvalid=%b reg3=%h need 1/44440000", bvalid, slv_regs[127:96]);
    end
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_same_edge_rw();
    bit hold_bad = 1'b0;
    @(negedge clk);
    awaddr = 4'h4; awvalid = 1'b1; wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1122_CC44 || bvalid !== 1'b1) begin
      fails++;
      $display("FAIL same_edge_old: rvalid=%b rdata=%h bvalid=%b need 1/1122CC44/1", rvalid, rdata, bvalid);
    end
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    araddr = 4'h4; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rvalid !== 1'b1 || rdata !== 32'h0000_0055 || arready !== 1'b0) hold_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (hold_bad) begin
      fails++;
      $display("FAIL rready_hold: rvalid=%b rdata=%h arready=%b need 1/00000055/0", rvalid, rdata, arready);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      fails++;
      $display("FAIL rready_release: rvalid=%b arready=%b need 0/1", rvalid, arready);
    end
  endtask

  task automatic test_reset_inflight_alias();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok, ok2;
    @(negedge clk);
    awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      fails++;
      $display("FAIL inflight_setup: bvalid=%b rvalid=%b need 1/1", bvalid, rvalid);
    end
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || slv_regs !== 128'h0 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL inflight_reset: bvalid=%b rvalid=%b regs=%h rdata=%h need 0/0/0/0", bvalid, rvalid, slv_regs, rdata);
    end
    aresetn = 1'b1;
    axi_write(4'h0, 32'h0000_0007, 4'hF, resp, ok);
    axi_read(4'h0 + 4'h0, d, resp, ok2);
    araddr = 4'h0;
    axi_read(4'h0, d, resp, ok2);
    checks++;
    if (!ok || !ok2 || d !== 32'h0000_0007) begin
      fails++;
      $display("FAIL reg0_after_reset: rdata=%h need 00000007", d);
    end
  endtask

  // Alias check: a 5-bit address 0x10 truncates to 0x0 on this 4-bit bus.
  task automatic test_alias();
    logic [1:0]  resp;
    logic [31:0] d;
    logic [4:0]  addr5;
    bit ok;
    addr5 = 5'h10;
    axi_read(addr5[3:0], d, resp, ok);
    checks++;
    if (!ok || d !== 32'h0000_0007) begin
      fails++;
      $display("FAIL alias_0x10: rdata=%h need 00000007", d);
    end
    axi_read(4'h9, d, resp, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      fails++;
      $display("FAIL low_bits_ignored: rdata=%h need 00000000", d);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = 4'h0; awprot = 3'b000; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 4'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_basic_rw();
    test_w_before_aw();
    test_strobes();
    test_bready_stall();
    test_same_edge_rw();
    test_reset_inflight_alias();
    test_alias();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
